// File: rtl/load_store_unit_pkg.sv
// Shared LSU types: FSM state encoding, RV32I load/store width codes, data width.
package pkg_config;

  localparam int LSU_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_READ,
    STORE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_align.sv
// Lane extraction/extension for loads and byte/halfword merge for stores (little-endian).
module lsu_align
  import pkg_config::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      LSU_B:   load_data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      LSU_BU:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      LSU_H:   load_data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      LSU_HU:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: load_data = word;
    endcase
  end

  // Store width only depends on funct3[1:0]; the sign bit is meaningless for stores.
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      2'b00:   store_word[{offset, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit in front of a combinational-read data memory.
module load_store_unit
  import pkg_config::*;
#(
  parameter int MEM_SIZE   = 1024,
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int AW         = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  lsu_state_e            state;
  logic [AW-1:0]         addr_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  fault;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_word;

  // Fault is judged on the raw request so out-of-range bits above AW are seen.
  always_comb begin
    fault = (addr_i >= 32'(MEM_SIZE));
    case (funct3_i)
      LSU_B, LSU_BU: begin end
      LSU_H, LSU_HU: fault = fault | addr_i[0];
      LSU_W:         fault = fault | (addr_i[1:0] != 2'b00);
      default:       fault = 1'b1;
    endcase
  end

  assign mem_addr_o = {addr_q[AW-1:2], 2'b00};

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .word       (mem_rdata_i),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      ready_o     <= 1'b1;
      rvalid_o    <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          addr_q   <= addr_i[AW-1:0];
          funct3_q <= funct3_i;
          wdata_q  <= wdata_i;
          ready_o  <= 1'b0;
          if (fault) begin
            state    <= RESP;
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= '0;
          end else if (!we_i) begin
            state <= LOAD;
          end else if (funct3_i == LSU_W) begin
            state       <= STORE;
            mem_we_o    <= 1'b1;
            mem_wdata_o <= wdata_i;
          end else begin
            state <= RMW_READ;
          end
        end
        LOAD: begin
          rdata_o  <= load_data;
          rvalid_o <= 1'b1;
          state    <= RESP;
        end
        RMW_READ: begin
          mem_wdata_o <= store_word;
          mem_we_o    <= 1'b1;
          state       <= STORE;
        end
        STORE: begin
          mem_we_o <= 1'b0;
          rvalid_o <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          rvalid_o <= 1'b0;
          err_o    <= 1'b0;
          ready_o  <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          ready_o  <= 1'b1;
          rvalid_o <= 1'b0;
          err_o    <= 1'b0;
          mem_we_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
